// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a framed byte stream (magic, count, words, XOR checksum),
// writes each 16-bit word to successive halfword addresses and holds the CPU in reset until the load verifies.
module imem_loader #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [15:0] MAGIC       = 16'hA55A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        clear,
  output logic        im_we,
  output logic [15:0] im_addr,
  output logic [15:0] im_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [3:0] {
    S_MAG_HI,
    S_MAG_LO,
    S_CNT_HI,
    S_CNT_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  logic [7:0]  r_hi;
  logic [7:0]  r_csum;
  logic [15:0] r_cnt;
  logic [15:0] r_words;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_we;
  logic        r_cpu_rst;
  logic        r_done;
  logic        r_error;

  logic        w_xfer;
  logic [15:0] w_word;

  assign in_ready     = (r_state != S_DONE) && (r_state != S_ERR);
  assign w_xfer       = in_valid & in_ready;
  assign w_word       = {r_hi, in_data};

  assign im_we        = r_we;
  assign im_addr      = r_addr;
  assign im_wdata     = r_wdata;
  assign cpu_rst      = r_cpu_rst;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_MAG_HI;
      r_hi      <= '0;
      r_csum    <= '0;
      r_cnt     <= '0;
      r_words   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_MAG_HI: if (w_xfer) begin
          r_hi    <= in_data;
          r_state <= S_MAG_LO;
        end
        S_MAG_LO: if (w_xfer) begin
          if (w_word == MAGIC) begin
            r_state <= S_CNT_HI;
          end else begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end
        end
        S_CNT_HI: if (w_xfer) begin
          r_hi    <= in_data;
          r_state <= S_CNT_LO;
        end
        S_CNT_LO: if (w_xfer) begin
          r_cnt <= w_word;
          if (w_word > 16'(DEPTH_WORDS)) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end else if (w_word == 16'd0) begin
            r_state <= S_CHK;
          end else begin
            r_state <= S_DAT_HI;
          end
        end
        S_DAT_HI: if (w_xfer) begin
          r_hi    <= in_data;
          r_csum  <= r_csum ^ in_data;
          r_state <= S_DAT_LO;
        end
        S_DAT_LO: if (w_xfer) begin
          // r_words doubles as the word index k for address generation
          r_we    <= 1'b1;
          r_addr  <= BASE_ADDR + {r_words[14:0], 1'b0};
          r_wdata <= w_word;
          r_words <= r_words + 16'd1;
          r_csum  <= r_csum ^ in_data;
          r_state <= (r_words + 16'd1 == r_cnt) ? S_CHK : S_DAT_HI;
        end
        S_CHK: if (w_xfer) begin
          if (in_data == r_csum) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b0;
          end else begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end
        end
        S_DONE, S_ERR: if (clear) begin
          r_state   <= S_MAG_HI;
          r_cpu_rst <= 1'b1;
          r_done    <= 1'b0;
          r_error   <= 1'b0;
          r_words   <= '0;
          r_csum    <= '0;
        end
        default: begin
          r_state <= S_ERR;
          r_error <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a negedge monitor pops and checks them.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        clear;
  logic        im_we;
  logic [15:0] im_addr;
  logic [15:0] im_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];
  logic        prev_we  = 1'b0;

  imem_loader #(
    .BASE_ADDR  (16'h0000),
    .DEPTH_WORDS(256),
    .MAGIC      (16'hA55A)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .clear       (clear),
    .im_we       (im_we),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .cpu_rst     (cpu_rst),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {im_addr, im_wdata}, 32'hxxxxxxxx);
      end else begin
        chk("write_addr_data", {im_addr, im_wdata}, exp_q.pop_front());
      end
      if (prev_we) chk("we_back_to_back", 32'(prev_we), 32'd0);
    end
    prev_we = im_we;
  end

  // Called at a negedge; returns at the negedge after the byte transfers.
  task automatic send(input logic [7:0] b, input int unsigned g);
    int unsigned idle;
    bit ok;
    idle = (g == 0) ? 0 : $urandom_range(0, g);
    repeat (idle) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    in_valid = 1'b0;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [15:0] w, input logic [15:0] addr, input int unsigned g);
    send(w[15:8], g);
    exp_q.push_back({addr, w});
    send(w[7:0], g);
  endtask

  task automatic good_frame(input logic [7:0] csum, input int unsigned g);
    send(8'hA5, g); send(8'h5A, g); send(8'h00, g); send(8'h02, g);
    send_word(16'h1234, 16'h0000, g);
    send_word(16'hABCD, 16'h0002, g);
    send(csum, g);
  endtask

  task automatic check_status(input string tag, input logic e_done, input logic e_err,
                              input logic e_cpu, input logic e_rdy, input logic [15:0] e_words);
    chk({tag, "_done"},     32'(done),         32'(e_done));
    chk({tag, "_error"},    32'(error),        32'(e_err));
    chk({tag, "_cpu_rst"},  32'(cpu_rst),      32'(e_cpu));
    chk({tag, "_in_ready"}, 32'(in_ready),     32'(e_rdy));
    chk({tag, "_words"},    32'(words_loaded), 32'(e_words));
    chk({tag, "_queue"},    exp_q.size(),      32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_status("clear", 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_status("reset", 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    chk("reset_addr_data", {im_addr, im_wdata}, 32'h0);

    good_frame(8'h40, 0);
    check_status("good", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);

    do_clear();
    send(8'hA5, 0); send(8'h5A, 0); send(8'h00, 0); send(8'h01, 0);
    send_word(16'h0007, 16'h0000, 0);
    send(8'h07, 0);
    check_status("reload", 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);

    do_clear();
    send(8'hA5, 0); send(8'h5B, 0);
    check_status("bad_magic", 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);

    do_clear();
    send(8'hA5, 0); send(8'h5A, 0); send(8'h01, 0); send(8'h01, 0);
    check_status("oversize", 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);

    // 256 words {k, ~k}: every word XORs to FF, so 256 of them give a checksum of 00
    do_clear();
    send(8'hA5, 0); send(8'h5A, 0); send(8'h01, 0); send(8'h00, 0);
    for (int k = 0; k < 256; k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      send_word({kb, ~kb}, 16'(2 * k), 0);
    end
    send(8'h00, 0);
    check_status("max_depth", 1'b1, 1'b0, 1'b0, 1'b0, 16'd256);
    chk("max_depth_last_addr", 32'(im_addr), 32'h01FE);

    do_clear();
    good_frame(8'h41, 0);
    check_status("bad_csum", 1'b0, 1'b1, 1'b1, 1'b0, 16'd2);

    do_clear();
    good_frame(8'h40, 3);
    check_status("stalled", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);

    do_clear();
    send(8'hA5, 0); send(8'h5A, 0); send(8'h00, 0); send(8'h02, 0); send(8'h12, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_status("mid_rst", 1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
    chk("mid_rst_addr_data", {im_addr, im_wdata}, 32'h0);
    chk("mid_rst_we", 32'(im_we), 32'd0);

    good_frame(8'h40, 0);
    check_status("after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);

    repeat (3) @(negedge clk);
    chk("final_queue", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
